// File: rtl/if_id_squash_reg.sv
// IF/ID pipeline register that replaces squashed fetch slots with NOP after a flush.
// Optional bubble counter is built only when IF_ID_BUBBLE_CNT_EN is defined.
module if_id_squash_reg #(
  parameter int unsigned INST_W        = 32,
  parameter int unsigned PC_W          = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h13,
  parameter int unsigned NUM_FLUSH_SRC = 2,
  parameter int unsigned SQUASH_CYCLES = 1,
  localparam int unsigned CAUSE_W = (NUM_FLUSH_SRC > 1) ? $clog2(NUM_FLUSH_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INST_W-1:0]        if_inst,
  input  logic [PC_W-1:0]          if_pc,
  input  logic                     if_valid,
  input  logic                     id_stall,
  input  logic [NUM_FLUSH_SRC-1:0] flush_req,
  output logic [INST_W-1:0]        id_inst,
  output logic [PC_W-1:0]          id_pc,
  output logic                     id_valid,
  output logic                     id_bubble,
  output logic                     squash_busy,
  output logic [CAUSE_W-1:0]       flush_cause,
  output logic [31:0]              bubble_cnt
);

  // state  | meaning
  // IDLE   | squash counter is zero; accepted fetches pass through
  // SQUASH | squash counter non-zero; accepted fetches become NOPs

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  if (SQUASH_CYCLES > 15) begin : g_sq_range_chk
    $error("if_id_squash_reg: SQUASH_CYCLES must be in 0..15");
  end
  if (NUM_FLUSH_SRC < 1) begin : g_src_range_chk
    $error("if_id_squash_reg: NUM_FLUSH_SRC must be at least 1");
  end

  logic [INST_W-1:0]  inst_q, inst_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;
  logic               bubble_q, bubble_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [0:0]         state_q, state_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [CAUSE_W-1:0] cause_win;
  logic               flush_any;
  logic               squash_ld;

  // Lowest set bit wins, so scan from the top down and let lower bits overwrite.
  always_comb begin
    cause_win = '0;
    for (int i = NUM_FLUSH_SRC - 1; i >= 0; i--) begin
      if (flush_req[i]) cause_win = CAUSE_W'(i);
    end
  end

  assign flush_any = |flush_req;

  always_comb begin
    inst_d    = inst_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    bubble_d  = bubble_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    cause_d   = cause_q;
    squash_ld = 1'b0;
    if (flush_any) begin
      inst_d    = NOP_INST;
      pc_d      = if_pc;
      valid_d   = 1'b0;
      bubble_d  = 1'b1;
      cnt_d     = 4'(SQUASH_CYCLES);
      state_d   = (SQUASH_CYCLES > 0) ? SQUASH : IDLE;
      cause_d   = cause_win;
      squash_ld = 1'b1;
    end else if (id_stall) begin
      // everything holds
    end else if (state_q == SQUASH && if_valid) begin
      inst_d    = NOP_INST;
      pc_d      = if_pc;
      valid_d   = 1'b0;
      bubble_d  = 1'b1;
      cnt_d     = cnt_q - 4'd1;
      state_d   = (cnt_q == 4'd1) ? IDLE : SQUASH;
      squash_ld = 1'b1;
    end else if (if_valid) begin
      inst_d   = if_inst;
      pc_d     = if_pc;
      valid_d  = 1'b1;
      bubble_d = 1'b0;
    end else begin
      // Empty fetch slot: NOP without consuming a squash credit.
      inst_d   = NOP_INST;
      valid_d  = 1'b0;
      bubble_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q   <= NOP_INST;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      bubble_q <= 1'b1;
      cnt_q    <= 4'd0;
      state_q  <= IDLE;
      cause_q  <= '0;
    end else begin
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      cause_q  <= cause_d;
    end
  end

`ifdef IF_ID_BUBBLE_CNT_EN
  logic [31:0] bcnt_q, bcnt_d;

  always_comb begin
    bcnt_d = bcnt_q;
    if (squash_ld) bcnt_d = bcnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bcnt_q <= 32'd0;
    else     bcnt_q <= bcnt_d;
  end

  assign bubble_cnt = bcnt_q;
`else
  logic unused_squash_ld;
  assign unused_squash_ld = squash_ld;
  assign bubble_cnt       = 32'h0;
`endif

  assign id_inst     = inst_q;
  assign id_pc       = pc_q;
  assign id_valid    = valid_q;
  assign id_bubble   = bubble_q;
  assign squash_busy = (state_q == SQUASH);
  assign flush_cause = cause_q;

endmodule

// File: tb/tb_if_id_squash_reg.sv
// Bench for if_id_squash_reg: three instances with SQUASH_CYCLES = 1, 2, 3 share one stimulus
// stream and are compared against a rule-level reference model plus directed expectations.
module tb_if_id_squash_reg;

  localparam logic [31:0] NOP = 32'h13;
  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        id_stall;
  logic [1:0]  flush_req;

  logic [31:0] o_inst   [NDUT];
  logic [31:0] o_pc     [NDUT];
  logic        o_valid  [NDUT];
  logic        o_bubble [NDUT];
  logic        o_busy   [NDUT];
  logic        o_cause  [NDUT];
  logic [31:0] o_bcnt   [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    if_id_squash_reg #(.SQUASH_CYCLES(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .if_inst    (if_inst),
      .if_pc      (if_pc),
      .if_valid   (if_valid),
      .id_stall   (id_stall),
      .flush_req  (flush_req),
      .id_inst    (o_inst[g]),
      .id_pc      (o_pc[g]),
      .id_valid   (o_valid[g]),
      .id_bubble  (o_bubble[g]),
      .squash_busy(o_busy[g]),
      .flush_cause(o_cause[g]),
      .bubble_cnt (o_bcnt[g])
    );
  end

  // Reference model: what ID should hold, plus how many accepted fetches remain to be squashed.
  logic [31:0] m_inst   [NDUT];
  logic [31:0] m_pc     [NDUT];
  logic        m_valid  [NDUT];
  int          m_left   [NDUT];
  logic        m_cause  [NDUT];
  logic [31:0] m_bcnt   [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_inst[k] = NOP; m_pc[k] = 0; m_valid[k] = 0;
      m_left[k] = 0; m_cause[k] = 0; m_bcnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NDUT; k++) begin
      if (flush_req != 2'b00) begin
        m_inst[k] = NOP; m_valid[k] = 0; m_pc[k] = if_pc;
        m_left[k] = k + 1;
        m_cause[k] = flush_req[0] ? 1'b0 : 1'b1;
        m_bcnt[k] = m_bcnt[k] + 1;
      end else if (id_stall) begin
      end else if (if_valid && m_left[k] > 0) begin
        m_inst[k] = NOP; m_valid[k] = 0; m_pc[k] = if_pc;
        m_left[k] = m_left[k] - 1;
        m_bcnt[k] = m_bcnt[k] + 1;
      end else if (if_valid) begin
        m_inst[k] = if_inst; m_valid[k] = 1; m_pc[k] = if_pc;
      end else begin
        m_inst[k] = NOP; m_valid[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] eb;
    for (int k = 0; k < NDUT; k++) begin
`ifdef IF_ID_BUBBLE_CNT_EN
      eb = m_bcnt[k];
`else
      eb = 32'h0;
`endif
      chk("model_inst",   k, o_inst[k],   m_inst[k]);
      chk("model_pc",     k, o_pc[k],     m_pc[k]);
      chk("model_valid",  k, o_valid[k],  m_valid[k]);
      chk("model_bubble", k, o_bubble[k], !m_valid[k]);
      chk("model_busy",   k, o_busy[k],   m_left[k] > 0);
      chk("model_cause",  k, o_cause[k],  m_cause[k]);
      chk("model_bcnt",   k, o_bcnt[k],   eb);
    end
  endtask

  // Inputs are driven at the falling edge; the model advances on the rising edge.
  task automatic drive(input logic v, input logic s, input logic [1:0] f,
                       input logic [31:0] inst, input logic [31:0] pc);
    if_valid = v; id_stall = s; flush_req = f; if_inst = inst; if_pc = pc;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 2'b00, 0, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  typedef struct {
    logic        valid;
    logic        stall;
    logic [1:0]  flush;
    logic [31:0] inst;
    logic [31:0] exp_inst;
    logic        exp_valid;
    logic        exp_busy;
    logic        exp_cause;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] exp_v;
    logic [7:0] exp_b;

    tbl[0] = '{1'b1, 1'b0, 2'b10, 32'hA000_0001, NOP,          1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 2'b00, 32'hB000_0002, NOP,          1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 2'b00, 32'hC000_0003, 32'hC000_0003, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 2'b11, 32'hD000_0004, NOP,          1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 2'b00, 32'hE000_0005, NOP,          1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 2'b00, 32'hF000_0006, NOP,          1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 2'b00, 32'h1111_0007, NOP,          1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 2'b00, 32'h2222_0008, 32'h2222_0008, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    drive(0, 0, 2'b00, 0, 0);
    model_reset();
    #2;
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_inst",   k, o_inst[k],   NOP);
      chk("rst_valid",  k, o_valid[k],  1'b0);
      chk("rst_bubble", k, o_bubble[k], 1'b1);
      chk("rst_busy",   k, o_busy[k],   1'b0);
      chk("rst_bcnt",   k, o_bcnt[k],   32'h0);
    end
    do_reset();

    // Reset asserted between edges must clear ID immediately.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 2'b00, 32'h0050_0093, 32'h100 + 32'(4 * i));
      cycle();
    end
    chk("pre_rst_valid", 0, o_valid[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("async_rst_inst",  k, o_inst[k],  NOP);
      chk("async_rst_valid", k, o_valid[k], 1'b0);
      chk("async_rst_pc",    k, o_pc[k],    32'h0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Table: flush, squash, stall-overridden flush, idle slot inside squash (SQUASH_CYCLES=1 instance).
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].valid, tbl[i].stall, tbl[i].flush, tbl[i].inst, 32'h2000 + 32'(4 * i));
      cycle();
      chk($sformatf("tbl%0d_inst", i),  0, o_inst[0],  tbl[i].exp_inst);
      chk($sformatf("tbl%0d_valid", i), 0, o_valid[0], tbl[i].exp_valid);
      chk($sformatf("tbl%0d_busy", i),  0, o_busy[0],  tbl[i].exp_busy);
      chk($sformatf("tbl%0d_cause", i), 0, o_cause[0], tbl[i].exp_cause);
    end

    // Re-flush during squash on the SQUASH_CYCLES=3 instance.
    do_reset();
    exp_v = 8'b1000_0000;
    exp_b = 8'b0011_1111;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, (i == 0 || i == 3) ? 2'b01 : 2'b00, 32'h3300_0000 + 32'(i), 32'h3000 + 32'(4 * i));
      cycle();
      chk($sformatf("reflush%0d_valid", i), 2, o_valid[2], exp_v[i]);
      chk($sformatf("reflush%0d_busy", i),  2, o_busy[2],  exp_b[i]);
    end
    chk("reflush_last_inst", 2, o_inst[2], 32'h3300_0007);

    // Stall then empty slot inside squash on the SQUASH_CYCLES=2 instance.
    do_reset();
    drive(1, 0, 2'b10, 32'h4400_0000, 32'h4000);
    cycle();
    for (int i = 1; i <= 2; i++) begin
      drive(1, 1, 2'b00, 32'h4400_0000 + 32'(i), 32'h4000 + 32'(4 * i));
      cycle();
      chk($sformatf("stall%0d_pc", i),   1, o_pc[1],   32'h4000);
      chk($sformatf("stall%0d_busy", i), 1, o_busy[1], 1'b1);
    end
    drive(0, 0, 2'b00, 32'h4400_0003, 32'h400C);
    cycle();
    chk("idle_pc",   1, o_pc[1],   32'h4000);
    chk("idle_busy", 1, o_busy[1], 1'b1);
    for (int i = 4; i <= 6; i++) begin
      drive(1, 0, 2'b00, 32'h4400_0000 + 32'(i), 32'h4000 + 32'(4 * i));
      cycle();
    end
    chk("post_squash_inst",  1, o_inst[1],  32'h4400_0006);
    chk("post_squash_valid", 1, o_valid[1], 1'b1);

    // Five isolated flushes: each gives one flush NOP and one squashed NOP on SQUASH_CYCLES=1.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 2'b01, 32'h5500_0000, 32'h5000);
      cycle();
      drive(1, 0, 2'b00, 32'h5500_0001, 32'h5004);
      cycle();
      drive(1, 0, 2'b00, 32'h5500_0002, 32'h5008);
      cycle();
    end
`ifdef IF_ID_BUBBLE_CNT_EN
    chk("bubble_cnt_5_flush", 0, o_bcnt[0], 32'd10);
`else
    chk("bubble_cnt_disabled", 0, o_bcnt[0], 32'd0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 5) == 0,
            (($urandom % 8) == 0) ? 2'($urandom % 4) : 2'b00,
            $urandom, $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_squash_reg.md
Name: if_id_squash_reg

Overview:
- Parametrised IF/ID pipeline register with NOP squashing; successor to the combinational IF-stage NOP substitution.
- Registers the fetched instruction and PC into ID and replaces the instruction with NOP on any of N flush sources (mret, branch/jump, trap, ...).
- Keeps squashing a configurable number of following in-flight fetches after a redirect.
- Supports ID stall (hold) and reports the last flush cause.

Parameters:
- INST_W, 32, instruction width.
- PC_W, 32, PC width.
- NOP_INST, 32'h13, value injected for squashed slots (addi x0,x0,0); width INST_W.
- NUM_FLUSH_SRC, 2, number of flush request inputs; minimum 1.
- SQUASH_CYCLES, 1, extra accepted fetches to squash after the flush cycle; 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- if_inst  in  INST_W  fetched instruction.
- if_pc  in  PC_W  PC of if_inst.
- if_valid  in  1  if_inst/if_pc valid this cycle.
- id_stall  in  1  ID cannot accept; hold register contents.
- flush_req  in  NUM_FLUSH_SRC  per-source flush request; bit 0 has highest priority.
- id_inst  out  INST_W  registered instruction to ID.
- id_pc  out  PC_W  registered PC.
- id_valid  out  1  id_inst is a real, non-squashed instruction.
- id_bubble  out  1  current id_inst is an injected NOP.
- squash_busy  out  1  squash counter non-zero.
- flush_cause  out  max(1,$clog2(NUM_FLUSH_SRC))  index of the winning source of the most recent flush.
- bubble_cnt  out  32  bubbles-inserted count (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - id_inst=NOP_INST, id_pc=0, id_valid=0, id_bubble=1.
  - Squash counter=0, squash_busy=0, flush_cause=0, bubble_cnt=0.
- States:
  - IDLE: counter==0.
  - SQUASH: counter>0.
  - squash_busy = (state==SQUASH).
- Each rising edge, in priority order:
  1. Flush (|flush_req=1):
     - Load id_inst=NOP_INST, id_valid=0, id_bubble=1; id_pc loads if_pc.
     - Counter loads SQUASH_CYCLES; state becomes SQUASH if SQUASH_CYCLES>0, else IDLE.
     - flush_cause loads the lowest set bit index of flush_req.
     - Flush overrides id_stall.
     - A flush while already in SQUASH reloads the counter; no accumulation.
  2. Else if id_stall=1:
     - All registers hold; counter holds.
  3. Else if state==SQUASH and if_valid=1:
     - Load NOP_INST, id_valid=0, id_bubble=1; id_pc loads if_pc.
     - Counter decrements; SQUASH→IDLE when it reaches 0.
  4. Else if if_valid=1:
     - Load if_inst/if_pc, id_valid=1, id_bubble=0.
  5. Else (if_valid=0, no stall):
     - Load NOP_INST, id_valid=0, id_bubble=1.
     - id_pc holds; counter holds (only accepted fetches are counted).
- Latency: 1 cycle IF→ID. Outputs are registered only; no combinational path from flush_req to id_inst.
- Counter width: 4 bits. SQUASH_CYCLES>15 is a compile-time error (generate-time check).
- bubble_cnt increments on every edge that loads an injected NOP due to rule 1 or 3. It wraps at 2^32-1 → 0.

Optional Feature:
- Macro: IF_ID_BUBBLE_CNT_EN.
- Defined: bubble_cnt is a live 32-bit saturating-free wrapping counter per the rules above.
- Not defined: no counter flops; bubble_cnt tied to 32'h0.

Test Plan:
- Reset mid-stream:
  - Stimulus: if_valid=1, if_inst=32'h00500093 for 3 cycles, then rst pulse between edges.
  - Required response: id_inst=32'h13, id_valid=0, id_pc=0 immediately, before the next edge.
- Single flush, SQUASH_CYCLES=1:
  - Stimulus: flush_req=2'b10 at edge N with fetches A,B,C on edges N..N+2.
  - Required response:
    - Edge N: NOP, flush_cause=1, squash_busy=1.
    - Edge N+1: NOP, squash_busy=0.
    - Edge N+2: id_inst=C, id_valid=1.
- Simultaneous sources and stall:
  - Stimulus: flush_req=2'b11 with id_stall=1.
  - Required response: NOP loaded despite stall; flush_cause=0.
- Re-flush during squash:
  - Stimulus: SQUASH_CYCLES=3; second flush arrives 2 accepted fetches after the first.
  - Required response: counter reloads to 3; 3 more NOPs follow before a real instruction.
- Stall and idle in SQUASH:
  - Stimulus: SQUASH_CYCLES=2; after the flush, 2 cycles of id_stall=1, then 1 cycle of if_valid=0, then 2 valid fetches.
  - Required response:
    - Register holds during the stall.
    - Counter stays at 2 through the stall and if_valid=0 cycles.
    - Both following fetches are squashed; next fetch passes.
- Bubble counter:
  - Stimulus: IF_ID_BUBBLE_CNT_EN defined, SQUASH_CYCLES=1, 5 isolated flushes.
  - Required response: bubble_cnt=10.
  - With the macro undefined, bubble_cnt=0.
